// File: rtl/axis_y_collector_if.sv
// Bus bundle for the y collector: AXI-stream input, AXI-lite control/readback
// and the single-port output BRAM. The slave modport is the collector's view.
interface axis_y_collector_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    // AXI-stream (FIR y in)
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;
    // AXI-lite
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;
    // output BRAM
    logic [3:0]             out_WE;
    logic                   out_EN;
    logic [pDATA_WIDTH-1:0] out_Di;
    logic [pADDR_WIDTH-1:0] out_A;
    logic [pDATA_WIDTH-1:0] out_Do;

    modport slave (
        input  ss_tvalid, ss_tdata, ss_tlast,
        output ss_tready,
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata,
        output out_WE, out_EN, out_Di, out_A,
        input  out_Do
    );

    modport master (
        output ss_tvalid, ss_tdata, ss_tlast,
        input  ss_tready,
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata,
        input  out_WE, out_EN, out_Di, out_A,
        output out_Do
    );
endinterface

// File: rtl/axis_y_collector.sv
// Captures a stream of FIR y samples into an output BRAM, tracking count,
// checksum and framing errors. AXI-lite exposes control/status and a
// read window onto the buffer. The stream owns the BRAM port; buffer reads
// are slipped a cycle whenever they collide with an accepted beat.
module axis_y_collector #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 64
) (
    input  logic               axis_clk,
    input  logic               axis_rst_n,
    axis_y_collector_if.slave  bus
);
    localparam int IDXW = $clog2(pDEPTH);

    typedef logic [pADDR_WIDTH-1:0] addr_t;
    typedef logic [pDATA_WIDTH-1:0] data_t;
    typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DONE} state_t;

    localparam addr_t A_CTRL    = addr_t'(12'h000);
    localparam addr_t A_EXP     = addr_t'(12'h004);
    localparam addr_t A_CNT     = addr_t'(12'h008);
    localparam addr_t A_SUM     = addr_t'(12'h00C);
    localparam addr_t A_ERR     = addr_t'(12'h010);
    localparam addr_t A_BUF     = addr_t'(12'h100);
    localparam addr_t A_BUF_END = addr_t'(32'h100 + 4 * pDEPTH);
    localparam data_t DEPTH_D   = data_t'(pDEPTH);

    state_t          state_q, state_d;
    addr_t           awaddr_q;
    data_t           wdata_q;
    logic            aw_held_q, w_held_q;
    data_t           exp_len_q, count_q, checksum_q;
    logic [2:0]      err_q;
    logic            done_q;
    logic            busy_q, rvalid_q, pend_q, fetch_q;
    logic [IDXW-1:0] pend_idx_q;
    data_t           rdata_q;

    // ---- decode --------------------------------------------------------
    logic            wr_commit, start_wr, beat, len_chk, hit_len, end_beat;
    logic            rd_acc, ar_is_buf, rd_now, idle;
    data_t           cnt_nx, reg_rdata;
    logic [IDXW-1:0] wr_idx, ar_idx, rd_idx;

    assign idle      = (state_q == S_IDLE);
    assign wr_commit = aw_held_q & w_held_q;
    assign start_wr  = wr_commit & (awaddr_q == A_CTRL) & wdata_q[0];
    assign beat      = bus.ss_tvalid & (state_q == S_CAPT);
    assign cnt_nx    = count_q + data_t'(1);
    // exp_len of zero disables the length check: first beat ends capture
    assign len_chk   = (exp_len_q != '0);
    assign hit_len   = len_chk & (cnt_nx == exp_len_q);
    assign end_beat  = beat & (bus.ss_tlast | hit_len | ~len_chk);
    assign wr_idx    = count_q[IDXW-1:0];

    assign rd_acc    = bus.arvalid & ~busy_q;
    assign ar_is_buf = (bus.araddr >= A_BUF) & (bus.araddr < A_BUF_END);
    assign ar_idx    = IDXW'((bus.araddr - A_BUF) >> 2);
    // present a buffer read only when the stream is not using the port
    assign rd_now    = ((rd_acc & ar_is_buf) | pend_q) & ~beat;
    assign rd_idx    = pend_q ? pend_idx_q : ar_idx;

    // ---- outputs -------------------------------------------------------
    assign bus.ss_tready = (state_q == S_CAPT);
    assign bus.awready   = ~aw_held_q;
    assign bus.wready    = ~w_held_q;
    assign bus.arready   = ~busy_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.out_EN    = 1'b1;
    assign bus.out_WE    = beat ? 4'hF : 4'h0;
    assign bus.out_Di    = beat ? bus.ss_tdata : '0;
    assign bus.out_A     = beat   ? addr_t'({wr_idx, 2'b00}) :
                           rd_now ? addr_t'({rd_idx, 2'b00}) : '0;

    // Register read mux, sampled in the address-accept cycle
    always_comb begin
        reg_rdata = '0;
        case (bus.araddr)
            A_CTRL:  reg_rdata = data_t'({idle, done_q, 1'b0});
            A_EXP:   reg_rdata = exp_len_q;
            A_CNT:   reg_rdata = count_q;
            A_SUM:   reg_rdata = checksum_q;
            A_ERR:   reg_rdata = data_t'(err_q);
            default: reg_rdata = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // FSM next state: start only honoured from IDLE, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_wr) state_d = S_CAPT;
            S_CAPT:  if (end_beat) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // AXI-lite write channel: address and data latched independently
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else if (wr_commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
        end else begin
            if (bus.awvalid && !aw_held_q) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= bus.awaddr;
            end
            if (bus.wvalid && !w_held_q) begin
                w_held_q <= 1'b1;
                wdata_q  <= bus.wdata;
            end
        end
    end

    // Capture bookkeeping: exp_len, count, checksum, errors, sticky done
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            exp_len_q  <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            if (wr_commit && awaddr_q == A_EXP) exp_len_q <= wdata_q;
            if (start_wr && idle) begin
                count_q    <= '0;
                checksum_q <= '0;
                err_q      <= '0;
                done_q     <= 1'b0;
            end else begin
                if (beat) begin
                    count_q    <= cnt_nx;
                    checksum_q <= checksum_q + bus.ss_tdata;
                    if (count_q >= DEPTH_D) err_q[2] <= 1'b1;
                    if (len_chk && bus.ss_tlast && cnt_nx < exp_len_q) err_q[0] <= 1'b1;
                    if (hit_len && !bus.ss_tlast) err_q[1] <= 1'b1;
                end
                if (state_q == S_DONE) done_q <= 1'b1;
            end
        end
    end

    // Read channel: one outstanding read, buffer reads go through BRAM
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            busy_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            fetch_q    <= 1'b0;
        end else begin
            pend_q  <= beat & ((rd_acc & ar_is_buf) | pend_q);
            fetch_q <= rd_now;
            if (rd_acc) begin
                busy_q <= 1'b1;
                if (ar_is_buf) begin
                    pend_idx_q <= ar_idx;
                end else begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= reg_rdata;
                end
            end
            if (fetch_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= bus.out_Do;
            end
            if (rvalid_q && bus.rready) begin
                rvalid_q <= 1'b0;
                busy_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_y_collector.sv
// Directed bench for axis_y_collector with a behavioural 1-cycle BRAM.
module tb_axis_y_collector;
    logic axis_clk = 1'b0;
    logic axis_rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    axis_y_collector_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus();

    axis_y_collector #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pDEPTH(64)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .bus        (bus)
    );

    always #5 axis_clk = ~axis_clk;

    // Output BRAM model: synchronous, read-first, data one cycle after address
    logic [31:0] bram [0:1023];
    always @(posedge axis_clk) begin
        if (bus.out_EN) begin
            if (bus.out_WE == 4'hF) bram[bus.out_A[11:2]] <= bus.out_Di;
            bus.out_Do <= bram[bus.out_A[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: timeout observed 1 expected 0", tag);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    // AXI-lite write; data raised wdly cycles after the address
    task automatic axil_write(input logic [11:0] a, input logic [31:0] d, input int wdly);
        bit ah, wh;
        int n;
        bus.awaddr = a; bus.wdata = d;
        bus.awvalid = 1'b1; bus.wvalid = (wdly == 0);
        n = 0;
        while ((bus.awvalid || bus.wvalid || n < wdly) && n < 50) begin
            @(negedge axis_clk);
            ah = bus.awvalid && bus.awready;
            wh = bus.wvalid && bus.wready;
            @(posedge axis_clk); #1;
            if (ah) bus.awvalid = 1'b0;
            if (wh) bus.wvalid = 1'b0;
            n++;
            if (n == wdly) bus.wvalid = 1'b1;
        end
        if (n >= 50) tmo("axil_write");
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        cyc(2);
    endtask

    // AXI-lite read; lat = edges after accept until rvalid, rready held low 'stall' cycles
    task automatic axil_read(input logic [11:0] a, input int stall,
                             output logic [31:0] d, output int lat);
        bit ok, stable;
        int n;
        logic [31:0] first;
        bus.araddr = a; bus.arvalid = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 20) begin
            @(negedge axis_clk); ok = bus.arready;
            @(posedge axis_clk); #1; n++;
        end
        bus.arvalid = 1'b0;
        if (!ok) tmo("ar_handshake");
        lat = 0;
        while (!bus.rvalid && lat < 20) begin
            @(posedge axis_clk); #1; lat++;
        end
        if (!bus.rvalid) tmo("rvalid_wait");
        first = bus.rdata; stable = 1;
        repeat (stall) begin
            @(posedge axis_clk); #1;
            if (bus.rdata !== first || !bus.rvalid) stable = 0;
        end
        if (stall > 0) chk("rdata_hold", {31'b0, stable}, 32'd1);
        bus.rready = 1'b1;
        @(posedge axis_clk); #1;
        bus.rready = 1'b0;
        d = first;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int lat;
        axil_read(a, 0, d, lat);
        chk(tag, d, exp);
    endtask

    // One stream beat; reports BRAM strobe/address seen in the accept cycle
    task automatic send_beat(input logic [31:0] d, input logic last,
                             output logic [11:0] a_seen, output logic [3:0] we_seen);
        bit ok;
        int n;
        bus.ss_tvalid = 1'b1; bus.ss_tdata = d; bus.ss_tlast = last;
        ok = 0; n = 0; a_seen = '0; we_seen = '0;
        while (!ok && n < 20) begin
            @(negedge axis_clk);
            ok = bus.ss_tready; a_seen = bus.out_A; we_seen = bus.out_WE;
            @(posedge axis_clk); #1; n++;
        end
        bus.ss_tvalid = 1'b0; bus.ss_tlast = 1'b0;
        if (!ok) tmo("beat_accept");
    endtask

    logic [11:0] a_s;
    logic [3:0]  we_s;
    logic [31:0] rd;
    int          lat;

    initial begin
        bus.ss_tvalid = 0; bus.ss_tdata = 0; bus.ss_tlast = 0;
        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;

        // ---- reset state ----
        cyc(3);
        chk("rst_tready",  {31'b0, bus.ss_tready}, 0);
        chk("rst_readies", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);
        chk("rst_rvalid",  {31'b0, bus.rvalid}, 0);
        chk("rst_rdata",   bus.rdata, 0);
        chk("rst_bram",    {16'b0, bus.out_A, bus.out_WE}, 0);
        chk("rst_di",      bus.out_Di, 0);
        axis_rst_n = 1'b1;
        cyc(2);
        axil_read(12'h000, 0, rd, lat);
        chk("rst_ctrl", rd, 32'h4);
        chk("lat_reg", 32'(lat), 0);
        rd_chk("rst_exp", 12'h004, 0);

        // ---- S1: exp_len=4, beats 1..4, tlast on 4th ----
        axil_write(12'h004, 4, 2);
        rd_chk("s1_exp", 12'h004, 4);
        axil_write(12'h000, 1, 0);
        chk("s1_tready", {31'b0, bus.ss_tready}, 1);
        rd_chk("s1_ctrl_capt", 12'h000, 0);
        send_beat(1, 0, a_s, we_s);
        chk("s1_b0_addr", {16'b0, a_s, we_s}, 32'h0000_000F);
        send_beat(2, 0, a_s, we_s);
        send_beat(3, 0, a_s, we_s);
        chk("s1_b2_addr", {16'b0, a_s, we_s}, 32'h0000_008F);
        send_beat(4, 1, a_s, we_s);
        chk("s1_tready_done", {31'b0, bus.ss_tready}, 0);
        cyc(2);
        rd_chk("s1_count", 12'h008, 4);
        rd_chk("s1_sum",   12'h00C, 10);
        rd_chk("s1_err",   12'h010, 0);
        rd_chk("s1_ctrl",  12'h000, 32'h6);
        axil_read(12'h100, 0, rd, lat);
        chk("s1_w0", rd, 1);
        chk("lat_buf", 32'(lat), 1);
        rd_chk("s1_w1", 12'h104, 2);
        rd_chk("s1_w2", 12'h108, 3);
        rd_chk("s1_w3", 12'h10C, 4);
        rd_chk("unmapped_14", 12'h014, 0);
        rd_chk("unmapped_20", 12'h020, 0);
        axil_write(12'h008, 32'h55, 1);
        rd_chk("ro_count", 12'h008, 4);

        // ---- S2: exp_len=5, early tlast on 3rd of 7,7,7 ----
        axil_write(12'h004, 5, 0);
        axil_write(12'h000, 1, 0);
        send_beat(7, 0, a_s, we_s);
        send_beat(7, 0, a_s, we_s);
        send_beat(7, 1, a_s, we_s);
        chk("s2_tready_done", {31'b0, bus.ss_tready}, 0);
        cyc(2);
        rd_chk("s2_count", 12'h008, 3);
        rd_chk("s2_err",   12'h010, 1);
        rd_chk("s2_sum",   12'h00C, 21);

        // ---- S3: exp_len=3, no tlast; restart attempt in CAPT ignored ----
        axil_write(12'h004, 3, 0);
        axil_write(12'h000, 1, 0);
        send_beat(10, 0, a_s, we_s);
        axil_write(12'h000, 1, 0);
        send_beat(11, 0, a_s, we_s);
        send_beat(12, 0, a_s, we_s);
        chk("s3_tready_done", {31'b0, bus.ss_tready}, 0);
        cyc(3);
        chk("s3_tready_after", {31'b0, bus.ss_tready}, 0);
        rd_chk("s3_err",   12'h010, 2);
        rd_chk("s3_count", 12'h008, 3);
        rd_chk("s3_sum",   12'h00C, 33);

        // ---- S4: exp_len=66, beats 0..65 wrap the 64-word buffer ----
        axil_write(12'h004, 66, 0);
        axil_write(12'h000, 1, 0);
        for (int i = 0; i < 66; i++) send_beat(i, (i == 65), a_s, we_s);
        chk("s4_wrap_addr", {16'b0, a_s, we_s}, 32'h0000_004F);
        cyc(2);
        rd_chk("s4_err", 12'h010, 4);
        rd_chk("s4_w0", 12'h100, 64);
        rd_chk("s4_w1", 12'h104, 65);
        rd_chk("s4_w2", 12'h108, 2);

        // ---- S5: gaps, collision read, rready stall ----
        axil_write(12'h004, 8, 0);
        axil_write(12'h000, 1, 0);
        for (int i = 0; i < 4; i++) begin
            send_beat(100 + i, 0, a_s, we_s);
            cyc($urandom_range(0, 3));
        end
        bus.ss_tvalid = 1'b1; bus.ss_tdata = 104; bus.ss_tlast = 1'b0;
        bus.araddr = 12'h104; bus.arvalid = 1'b1;
        @(negedge axis_clk);
        chk("s5_coll_setup", {30'b0, bus.ss_tready, bus.arready}, 32'h3);
        @(posedge axis_clk); #1;
        bus.ss_tvalid = 1'b0; bus.arvalid = 1'b0;
        lat = 0;
        while (!bus.rvalid && lat < 20) begin
            @(posedge axis_clk); #1; lat++;
        end
        chk("s5_coll_lat", 32'(lat), 2);
        chk("s5_coll_data", bus.rdata, 101);
        bus.rready = 1'b1;
        @(posedge axis_clk); #1;
        bus.rready = 1'b0;
        for (int i = 5; i < 8; i++) begin
            cyc($urandom_range(0, 2));
            send_beat(100 + i, (i == 7), a_s, we_s);
        end
        cyc(2);
        rd_chk("s5_sum", 12'h00C, 828);
        rd_chk("s5_err", 12'h010, 0);
        axil_read(12'h110, 3, rd, lat);
        chk("s5_w4_stall", rd, 104);

        // ---- S6: exp_len=0, single beat ends capture ----
        axil_write(12'h004, 0, 0);
        axil_write(12'h000, 1, 0);
        send_beat(9, 0, a_s, we_s);
        chk("s6_tready_done", {31'b0, bus.ss_tready}, 0);
        cyc(2);
        rd_chk("s6_count", 12'h008, 1);
        rd_chk("s6_err",   12'h010, 0);
        rd_chk("s6_ctrl",  12'h000, 32'h6);

        // ---- S7: reset mid-capture, then fresh capture ----
        axil_write(12'h004, 4, 0);
        axil_write(12'h000, 1, 0);
        send_beat(1, 0, a_s, we_s);
        send_beat(2, 0, a_s, we_s);
        axis_rst_n = 1'b0;
        cyc(2);
        axis_rst_n = 1'b1;
        cyc(1);
        chk("s7_tready", {31'b0, bus.ss_tready}, 0);
        rd_chk("s7_ctrl",  12'h000, 32'h4);
        rd_chk("s7_count", 12'h008, 0);
        axil_write(12'h004, 2, 0);
        axil_write(12'h000, 1, 0);
        send_beat(5, 0, a_s, we_s);
        send_beat(6, 1, a_s, we_s);
        cyc(2);
        rd_chk("s7_count2", 12'h008, 2);
        rd_chk("s7_sum2",   12'h00C, 11);
        rd_chk("s7_err2",   12'h010, 0);
        rd_chk("s7_w0",     12'h100, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
